// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the MEM-stage memory controller.
// Holds the FSM state encoding and the default ack timeout.
package mips_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: data-memory request/ack bus.
// master = MEM-stage controller, slave = data memory.
interface mem_stage_ctrl_if;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_ack,
      output mem_rdata
   );

endinterface

// File: rtl/mem_stage_ctrl_wait_timer.sv
// wait_timer: saturating cycle counter for the memory wait.
// tc flags the last allowed wait cycle (count == TIMEOUT-1).
module wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] count;

   // Clear on WAIT entry, count WAIT cycles, stop at the last one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + W'(1);
      end
   end

   assign tc = (count == LAST);

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: stalls the pipeline around a data-memory access,
// handles misaligned drops and ack timeouts.
module mem_stage_ctrl
   import mips_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    MemWriteM,
   input  logic                    MemtoRegM,
   input  logic [31:0]             ALUResM,
   input  logic [31:0]             RegD2M,
   mem_stage_ctrl_if.master        bus,
   output logic                    StallM,
   output logic                    FlushW,
   output logic [31:0]             ReadDataM,
   output logic                    misalign_err,
   output logic                    bus_err
);

   logic [1:0]  state;
   logic [1:0]  stateNext;
   logic        isIdle;
   logic        isWait;
   logic        access;
   logic        aligned;
   logic        start;
   logic        tc;
   logic        timeoutHit;
   logic        memWe;
   logic [31:0] memAddr;
   logic [31:0] memWdata;

   assign isIdle  = (state == S_IDLE);
   assign isWait  = (state == S_WAIT);
   assign access  = MemWriteM | MemtoRegM;
   assign aligned = (ALUResM[1:0] == 2'b00);
   assign start   = isIdle & access & aligned;

   assign timeoutHit = isWait & tc & ~bus.mem_ack;

   wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (start),
      .enable (isWait),
      .tc     (tc)
   );

   // Next-state: IDLE -> WAIT -> DONE -> IDLE; ack beats timeout.
   always_comb begin
      stateNext = state;
      unique case (1'b1)
         isIdle:  if (start) stateNext = S_WAIT;
         isWait:  if (bus.mem_ack | tc) stateNext = S_DONE;
         default: stateNext = S_IDLE;
      endcase
   end

   // State register; async reset aborts any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= stateNext;
   end

   // Latch the request when the access starts; held through WAIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         memWe    <= 1'b0;
         memAddr  <= '0;
         memWdata <= '0;
      end else if (start) begin
         memWe    <= MemWriteM;
         memAddr  <= ALUResM;
         memWdata <= RegD2M;
      end
   end

   // Load result: capture on read ack, zero on timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ReadDataM <= '0;
      end else if (isWait && bus.mem_ack && !memWe) begin
         ReadDataM <= bus.mem_rdata;
      end else if (timeoutHit) begin
         ReadDataM <= '0;
      end
   end

   assign bus.mem_req   = isWait;
   assign bus.mem_we    = memWe;
   assign bus.mem_addr  = memAddr;
   assign bus.mem_wdata = memWdata;

   assign StallM       = start | isWait;
   assign FlushW       = StallM;
   assign misalign_err = isIdle & access & ~aligned;
   assign bus_err      = timeoutHit;

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001: Parameter TIMEOUT, default 16, SHALL set the maximum wait cycles for mem_ack (legal range 2..255).
REQ-002: clk  input  1  single clock; all state updates on its rising edge.
REQ-003: rst  input  1  asynchronous, active-high reset.
REQ-004: MemWriteM  input  1  store in MEM stage, taken from the EX/MEM register.
REQ-005: MemtoRegM  input  1  load in MEM stage, taken from the EX/MEM register.
REQ-006: ALUResM  input  32  byte address of the access.
REQ-007: RegD2M  input  32  store data.
REQ-008: mem_req  output  1  request to data memory.
REQ-009: mem_we  output  1  1 = write, 0 = read.
REQ-010: mem_addr  output  32  latched access address.
REQ-011: mem_wdata  output  32  latched store data.
REQ-012: mem_ack  input  1  memory completion; one-cycle pulse.
REQ-013: mem_rdata  input  32  read data, valid when mem_ack = 1.
REQ-014: StallM  output  1  freezes PC, IF/ID, ID/EX and EX/MEM.
REQ-015: FlushW  output  1  loads a bubble into MEM/WB.
REQ-016: ReadDataM  output  32  registered load result.
REQ-017: misalign_err  output  1  access address has ALUResM[1:0] != 0.
REQ-018: bus_err  output  1  one-cycle pulse on timeout.

Function
REQ-019: The block SHALL implement FSM states IDLE, WAIT and DONE.
REQ-020: An access SHALL be defined as access = MemWriteM | MemtoRegM, with MemWriteM taking priority if both are 1.
REQ-021: IDLE, access with ALUResM[1:0] == 0: StallM SHALL be 1 combinationally; on the next edge the block SHALL latch mem_addr, mem_wdata and mem_we, and go to WAIT.
REQ-022: IDLE, access with ALUResM[1:0] != 0: misalign_err SHALL be 1 combinationally, there SHALL be no stall and no request, and the FSM SHALL stay in IDLE.
REQ-023: The access in REQ-022 SHALL be dropped; ReadDataM SHALL be unchanged.
REQ-024: mem_req SHALL equal (state == WAIT); mem_addr, mem_we and mem_wdata SHALL hold stable throughout WAIT.
REQ-025: WAIT counter behaviour:
- The wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
- Counter width SHALL be ceil(log2(TIMEOUT)) bits, with no wrap.
REQ-026: WAIT with mem_ack = 1: ReadDataM SHALL capture mem_rdata if mem_we = 0, else hold; next state DONE.
REQ-027: WAIT with counter == TIMEOUT-1 and mem_ack = 0: bus_err SHALL pulse for 1 cycle, ReadDataM SHALL be set to 0, next state DONE.
REQ-028: If mem_ack and the timeout coincide, ack SHALL win and there SHALL be no bus_err.
REQ-029: StallM SHALL equal (IDLE & aligned access) | WAIT; it SHALL be 0 in DONE so the pipeline advances at the end of DONE.
REQ-030: DONE SHALL go to IDLE unconditionally; DONE SHALL NOT start a new access, even though the same instruction is still in EX/MEM.
REQ-031: FlushW SHALL equal StallM.
REQ-032: mem_ack SHALL be ignored in IDLE and DONE.
REQ-033: Latency SHALL be ack cycles + 2 (fastest: ack in the first WAIT cycle gives 2 stall cycles plus 1 DONE cycle).

Reset
REQ-034: While rst = 1, the block SHALL asynchronously reset to:
- state = IDLE, counter = 0;
- mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, ReadDataM = 0, bus_err = 0.
REQ-035: A reset mid-WAIT SHALL abort the access: mem_req SHALL drop without waiting for a clock edge, and a later stale mem_ack SHALL be ignored.
REQ-036: After rst deasserts, StallM, FlushW and misalign_err SHALL follow only the combinational rules in REQ-021/022/029.

Structure
REQ-037: The FSM state encoding (IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2) and the default TIMEOUT SHALL live in the shared package mips_pkg.
REQ-038: The wait counter with terminal-count flag SHALL be a sub-module named wait_timer (inputs clear, enable; output tc).

Verification
REQ-039: Load: ALUResM = 0x100, MemtoRegM = 1, ack on the 3rd WAIT cycle with mem_rdata = 0xDEADBEEF -> StallM high 4 cycles, then DONE, ReadDataM = 0xDEADBEEF, mem_we = 0.
REQ-040: Store: ALUResM = 0x200, RegD2M = 0x12345678, ack in the 1st WAIT cycle -> mem_we = 1, mem_wdata = 0x12345678, StallM high 2 cycles, ReadDataM unchanged.
REQ-041: Timeout: TIMEOUT = 4, no ack -> bus_err pulses in the 4th WAIT cycle, ReadDataM = 0, then DONE -> IDLE.
REQ-042: Ack coinciding with timeout: TIMEOUT = 4, ack in the 4th WAIT cycle -> bus_err = 0, data captured.
REQ-043: Misaligned: ALUResM = 0x103, MemtoRegM = 1 -> misalign_err = 1, StallM = 0, mem_req stays 0.
REQ-044: Reset mid-WAIT: assert rst in the 2nd WAIT cycle -> mem_req = 0 immediately; a stale ack after reset -> ReadDataM stays 0, state IDLE.
